// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed, XOR-checked image into imem and holds the core in reset until it verifies.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] address_imem_wr,
  output logic [DATA_WIDTH-1:0] d_imem,
  output logic                  wren_imem,
  output logic                  proc_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;
  localparam logic [ADDR_WIDTH:0] W_ONE = 1;
  state_t state_q, state_d;
  logic [7:0] len_hi_q, csum_q;
  logic [ADDR_WIDTH:0] n_q, words_q;
  logic [1:0] idx_q;
  logic [23:0] asm_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic ready_q, wren_q, hold_q, done_q, err_q;
  logic ready_d, hold_d, done_d, err_d;
  logic acc, word_end, last_word, new_session;
  logic [15:0] n_full;
  assign acc         = in_valid && ready_q;
  assign n_full      = {len_hi_q, in_byte};
  assign word_end    = acc && state_q == S_DATA && idx_q == 2'd3;
  assign last_word   = (words_q + W_ONE) == n_q;
  assign new_session = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: state_d = start ? S_LEN_HI : state_q;
      S_LEN_HI: state_d = acc ? S_LEN_LO : state_q;
      S_LEN_LO: state_d = !acc ? state_q : 32'(n_full) > MAX_WORDS ? S_ERROR : n_full == 16'd0 ? S_CHECK : S_DATA;
      S_DATA:   state_d = (word_end && last_word) ? S_CHECK : state_q;
      S_CHECK:  state_d = !acc ? state_q : (in_byte == csum_q) ? S_DONE : S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
    hold_d  = state_d != S_DONE;
    done_d  = state_d == S_DONE;
    err_d   = state_d == S_ERROR;
  end
  // A completed word is written the cycle after its last byte, at the pre-increment count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_hi_q <= '0;
      n_q      <= '0;
      words_q  <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      asm_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
    end else begin
      wren_q <= word_end;
      if (new_session) begin
        words_q <= '0;
        csum_q  <= '0;
        idx_q   <= '0;
      end
      if (acc && state_q == S_LEN_HI) len_hi_q <= in_byte;
      if (acc && state_q == S_LEN_LO) n_q <= n_full[ADDR_WIDTH:0];
      if (acc && state_q == S_DATA) begin
        asm_q  <= {asm_q[15:0], in_byte};
        csum_q <= csum_q ^ in_byte;
        idx_q  <= idx_q + 2'd1;
      end
      if (word_end) begin
        addr_q  <= words_q[ADDR_WIDTH-1:0];
        data_q  <= {asm_q, in_byte};
        words_q <= words_q + W_ONE;
      end
    end
  end
  assign in_ready        = ready_q;
  assign address_imem_wr = addr_q;
  assign d_imem          = data_q;
  assign wren_imem       = wren_q;
  assign proc_hold       = hold_q;
  assign load_done       = done_q;
  assign load_error      = err_q;
  assign words_loaded    = words_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized and directed load sessions checked against a stream-level model of the loader.
module tb_imem_boot_loader;
  localparam int AW = 12;
  localparam int MAXW = 4096;
  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_ready, wren_imem, proc_hold, load_done, load_error;
  logic [AW-1:0] address_imem_wr;
  logic [31:0] d_imem;
  logic [AW:0] words_loaded;
  int n_cmp = 0, n_bad = 0;
  wr_t exp_q[$], got_q[$];
  logic [7:0] sq[$];
  int e_nacc, e_words;
  bit e_done, e_err;

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .address_imem_wr(address_imem_wr), .d_imem(d_imem),
    .wren_imem(wren_imem), .proc_hold(proc_hold), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) if (reset) begin
    wr_t w;
    chk("hold_vs_done", proc_hold, !load_done);
    if (wren_imem) begin
      got_q.push_back({address_imem_wr, d_imem});
      if (exp_q.size() == 0) chk("spurious_write", wren_imem, 0);
      else begin
        w = exp_q.pop_front();
        chk("wr_addr", address_imem_wr, w.a);
        chk("wr_data", d_imem, w.d);
        chk("wr_count", words_loaded, {1'b0, w.a} + 13'd1);
      end
    end
  end

  // Interprets a byte stream per the image format: what gets written and how it ends.
  task automatic model();
    int n;
    logic [7:0] x;
    logic [31:0] d;
    exp_q.delete();
    n = {sq[0], sq[1]};
    if (n > MAXW) begin
      e_nacc = 2; e_done = 0; e_err = 1; e_words = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      d = {sq[2+4*i], sq[3+4*i], sq[4+4*i], sq[5+4*i]};
      x = x ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      exp_q.push_back({i[AW-1:0], d});
    end
    e_nacc = 3 + 4 * n;
    e_done = (sq[2+4*n] == x);
    e_err = !e_done;
    e_words = n;
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] x, b;
    sq.delete();
    sq.push_back(n[15:8]);
    sq.push_back(n[7:0]);
    if (n > MAXW) return;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      sq.push_back(b);
      x ^= b;
    end
    sq.push_back(bad ? x ^ 8'($urandom_range(255, 1)) : x);
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit st);
    int t;
    repeat (gap) begin
      chk("ready_in_gap", in_ready, 1);
      @(negedge clock);
    end
    in_valid = 1'b1; in_byte = b; start = st; t = 0;
    while (!in_ready && t < 20) begin @(negedge clock); t++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_hold", proc_hold, 1);
    chk("start_words", words_loaded, 0);
    chk("start_done", load_done, 0);
    chk("start_err", load_error, 0);
    chk("start_ready", in_ready, 1);
  endtask

  task automatic run_session(input int maxgap, input bit fixed_gap, input int start_at);
    model();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < e_nacc; i++)
      send(sq[i], fixed_gap ? maxgap : $urandom_range(maxgap, 0), i == start_at);
    repeat (2) @(negedge clock);
    chk("end_done", load_done, e_done);
    chk("end_err", load_error, e_err);
    chk("end_hold", proc_hold, !e_done);
    chk("end_words", words_loaded, e_words);
    chk("end_pending_writes", exp_q.size(), 0);
    chk("end_ready", in_ready, 0);
  endtask

  task automatic load_sc1();
    sq = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h2D};
  endtask

  task automatic check_reset_values();
    chk("rst_ready", in_ready, 0);
    chk("rst_wren", wren_imem, 0);
    chk("rst_addr", address_imem_wr, 0);
    chk("rst_data", d_imem, 0);
    chk("rst_hold", proc_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    chk("rst_words", words_loaded, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    check_reset_values();
    #1 reset = 1'b1;
    @(negedge clock);
    // Scenario 1: model pinned against hand-computed values, DUT writes pinned too.
    load_sc1();
    model();
    chk("model_w0", exp_q[0].d, 32'h20000005);
    chk("model_w1", exp_q[1].d, 32'h12345678);
    chk("model_ok", e_done, 1);
    run_session(0, 1'b0, -1);
    chk("sc1_nwr", got_q.size(), 2);
    chk("sc1_w0", got_q[0], {12'h000, 32'h20000005});
    chk("sc1_w1", got_q[1], {12'h001, 32'h12345678});
    // Scenario 2: bad checksum
    load_sc1();
    sq[10] = 8'h2C;
    model();
    chk("model_bad", e_err, 1);
    run_session(0, 1'b0, -1);
    chk("sc2_nwr", got_q.size(), 2);
    // Scenario 3: length boundaries
    sq = '{8'h00, 8'h00, 8'h00};
    run_session(0, 1'b0, -1);
    chk("sc3_zero_nwr", got_q.size(), 0);
    sq = '{8'h10, 8'h01};
    model();
    chk("model_len_err", e_err, 1);
    run_session(0, 1'b0, -1);
    chk("sc3_big_nwr", got_q.size(), 0);
    // Scenario 4: three idle cycles before every byte
    load_sc1();
    run_session(3, 1'b1, -1);
    chk("sc4_nwr", got_q.size(), 2);
    // Scenario 5: reset mid-word, then two clean loads back to back
    load_sc1();
    exp_q.delete();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send(sq[i], 0, 1'b0);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_values();
    chk("sc5_nwr", got_q.size(), 0);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("sc5_idle_ready", in_ready, 0);
    load_sc1();
    run_session(0, 1'b0, -1);
    load_sc1();
    run_session(1, 1'b0, -1);
    // Scenario 6: start pulsed mid-data is ignored
    load_sc1();
    run_session(0, 1'b0, 5);
    chk("sc6_nwr", got_q.size(), 2);
    // Largest legal image
    build(MAXW, 1'b0);
    run_session(0, 1'b0, -1);
    chk("max_nwr", got_q.size(), MAXW);
    for (int k = 0; k < 25; k++) begin
      n = ($urandom_range(7, 0) == 0) ? $urandom_range(65535, MAXW + 1) : $urandom_range(8, 0);
      build(n, $urandom_range(3, 0) == 0);
      run_session(3, 1'b0, ($urandom_range(1, 0) == 1) ? $urandom_range(8, 3) : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
